// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared states, widths and flag bit positions for the ALU command sequencer.
package alu_seq_pkg;
  localparam int OP_WIDTH   = 3;
  localparam int DATA_WIDTH = 8;
  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;
  typedef enum logic [2:0] {GET_OP, GET_A, GET_B, EXEC, RESP} state_e;
endpackage

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: parses {OP,A,B} byte frames, drives the external ALU,
// waits ALU_LATENCY cycles, then returns the captured Y and {C,V,N,Z} on a valid/ready port.
module alu_cmd_sequencer #(
  parameter int ALU_LATENCY = 1,
  parameter int DATA_WIDTH  = 8,
  parameter int OP_WIDTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] alu_a_o,
  output logic [DATA_WIDTH-1:0] alu_b_o,
  output logic [OP_WIDTH-1:0]   alu_op_o,
  input  logic [DATA_WIDTH-1:0] alu_y_i,
  input  logic [3:0]            alu_flags_i,
  output logic [DATA_WIDTH-1:0] res_data_o,
  output logic [3:0]            res_flags_o,
  output logic                  res_err_o,
  output logic                  res_valid_o,
  input  logic                  res_ready_i,
  output logic [7:0]            frame_cnt_o
);
  import alu_seq_pkg::*;
  if (ALU_LATENCY < 1 || ALU_LATENCY > 15) begin : g_bad_latency
    $error("ALU_LATENCY must be in 1..15");
  end
  localparam logic [3:0] WAIT_INIT = 4'(ALU_LATENCY - 1);
  state_e                state_q, state_d;
  logic [3:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, res_data_q, res_data_d;
  logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
  logic [3:0]            res_flags_q, res_flags_d;
  logic                  res_err_q, res_err_d, res_valid_q, res_valid_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic                  in_ready, accept, handshake;
  assign in_ready  = state_q inside {GET_OP, GET_A, GET_B};
  assign accept    = in_ready && in_valid_i;
  assign handshake = res_valid_q && res_ready_i;
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    res_data_d  = res_data_q;
    res_flags_d = res_flags_q;
    res_err_d   = res_err_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      GET_OP: if (accept) begin
        if (|in_data_i[DATA_WIDTH-1:OP_WIDTH]) begin
          res_err_d   = 1'b1;
          res_data_d  = '0;
          res_flags_d = '0;
          state_d     = RESP;
        end else begin
          alu_op_d = in_data_i[OP_WIDTH-1:0];
          state_d  = GET_A;
        end
      end
      GET_A: if (accept) begin
        alu_a_d = in_data_i;
        state_d = GET_B;
      end
      GET_B: if (accept) begin
        alu_b_d = in_data_i;
        wait_d  = WAIT_INIT;
        state_d = EXEC;
      end
      EXEC: if (wait_q == 4'd0) begin
        res_data_d  = alu_y_i;
        res_flags_d = alu_flags_i;
        res_err_d   = 1'b0;
        state_d     = RESP;
      end else begin
        wait_d = wait_q - 4'd1;
      end
      RESP: if (handshake) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
        state_d     = GET_OP;
      end
      default: state_d = GET_OP;
    endcase
  end
  // Registered valid adds one bubble on RESP entry, keeping it free of any input-to-output path.
  assign res_valid_d = (state_q == RESP) && !handshake;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GET_OP;
      wait_q      <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      res_data_q  <= '0;
      res_flags_q <= '0;
      res_err_q   <= 1'b0;
      res_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      res_data_q  <= res_data_d;
      res_flags_q <= res_flags_d;
      res_err_q   <= res_err_d;
      res_valid_q <= res_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  assign in_ready_o  = in_ready;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_op_o    = alu_op_q;
  assign res_data_o  = res_data_q;
  assign res_flags_o = res_flags_q;
  assign res_err_o   = res_err_q;
  assign res_valid_o = res_valid_q;
  assign frame_cnt_o = frame_cnt_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: two sequencers (latency 1 and 3) each driving a behavioural ALU;
// table vectors plus hand-written corner sequences and random frames.
module tb_alu_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data[2];
  logic       in_valid[2], res_ready[2];
  logic       in_ready[2], res_valid[2], res_err[2];
  logic [7:0] alu_a[2], alu_b[2], alu_y[2], res_data[2], frame_cnt[2];
  logic [2:0] alu_op[2];
  logic [3:0] alu_flags[2], res_flags[2];
  logic [7:0] exp_cnt[2], exp_b[2];
  int         lat_of[2] = '{1, 3};
  int         errs = 0, checks = 0;
  always #5 clk = ~clk;
  alu_cmd_sequencer #(.ALU_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data[0]), .in_valid_i(in_valid[0]),
    .in_ready_o(in_ready[0]), .alu_a_o(alu_a[0]), .alu_b_o(alu_b[0]), .alu_op_o(alu_op[0]),
    .alu_y_i(alu_y[0]), .alu_flags_i(alu_flags[0]), .res_data_o(res_data[0]),
    .res_flags_o(res_flags[0]), .res_err_o(res_err[0]), .res_valid_o(res_valid[0]),
    .res_ready_i(res_ready[0]), .frame_cnt_o(frame_cnt[0]));
  alu_cmd_sequencer #(.ALU_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_data_i(in_data[1]), .in_valid_i(in_valid[1]),
    .in_ready_o(in_ready[1]), .alu_a_o(alu_a[1]), .alu_b_o(alu_b[1]), .alu_op_o(alu_op[1]),
    .alu_y_i(alu_y[1]), .alu_flags_i(alu_flags[1]), .res_data_o(res_data[1]),
    .res_flags_o(res_flags[1]), .res_err_o(res_err[1]), .res_valid_o(res_valid[1]),
    .res_ready_i(res_ready[1]), .frame_cnt_o(frame_cnt[1]));
  // ops: 0 add, 1 sub (C=borrow), 2 and, 3 or, 4 xor, 5 shl, 6 shr, 7 pass A
  function automatic logic [11:0] alu_model(input logic [2:0] op, input logic [7:0] a, b);
    logic [8:0] s;
    logic [7:0] y;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    s = {1'b0, a} + {1'b0, b};
    y = a;
    case (op)
      3'd0: begin y = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (y[7] != a[7]); end
      3'd1: begin y = a - b; c = a < b; v = (a[7] != b[7]) && (y[7] != a[7]); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: begin y = a << 1; c = a[7]; end
      3'd6: begin y = a >> 1; c = a[0]; end
      default: y = a;
    endcase
    return {c, v, y[7], y == 8'd0, y};
  endfunction
  always_comb begin
    for (int d = 0; d < 2; d++) {alu_flags[d], alu_y[d]} = alu_model(alu_op[d], alu_a[d], alu_b[d]);
  end
  typedef struct {
    logic [7:0] op, a, b, y;
    logic [3:0] f;
  } vec_t;
  vec_t tbl[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input int d, input logic [7:0] v, input int gap);
    int n;
    n = 0;
    repeat (gap) tick();
    in_valid[d] = 1'b1;
    in_data[d]  = v;
    while (!in_ready[d] && n < 50) begin
      tick();
      n++;
    end
    chk("send_stall", 32'(n < 50), 1);
    tick();
    in_valid[d] = 1'b0;
    in_data[d]  = 8'($urandom);
  endtask
  task automatic frame(input int d, input logic [7:0] op, a, b, ey, input logic [3:0] ef,
                       input int gmax, input bit pre);
    bit e;
    int lat;
    e = |op[7:3];
    if (pre) res_ready[d] = 1'b1;
    send(d, op, $urandom_range(0, gmax));
    if (!e) begin
      send(d, a, $urandom_range(0, gmax));
      chk("op_reg", alu_op[d], op[2:0]);
      chk("a_reg", alu_a[d], a);
      chk("b_held", alu_b[d], exp_b[d]);
      send(d, b, $urandom_range(0, gmax));
      chk("b_reg", alu_b[d], b);
      exp_b[d] = b;
    end
    lat = 0;
    while (!res_valid[d] && lat < 40) begin
      tick();
      lat++;
    end
    chk(d == 0 ? "latency_l1" : "latency_l3", lat, e ? 1 : lat_of[d] + 1);
    chk("res_data", res_data[d], ey);
    chk("res_flags", res_flags[d], ef);
    chk("res_err", res_err[d], e);
    res_ready[d] = 1'b1;
    tick();
    res_ready[d] = 1'b0;
    exp_cnt[d]++;
    chk("valid_drop", res_valid[d], 0);
    chk("frame_cnt", frame_cnt[d], exp_cnt[d]);
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", in_ready[d], 1);
      chk("rst_res_valid", res_valid[d], 0);
      chk("rst_cnt", frame_cnt[d], 0);
      chk("rst_alu", {alu_op[d], alu_a[d], alu_b[d]}, 0);
      chk("rst_res", {res_err[d], res_flags[d], res_data[d]}, 0);
      exp_cnt[d] = 8'd0;
      exp_b[d]   = 8'd0;
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bit ok;
    int n;
    logic [7:0] op, a, b;
    logic [11:0] m;
    tbl[0]  = '{8'h00, 8'h05, 8'h03, 8'h08, 4'h0};
    tbl[1]  = '{8'h28, 8'h00, 8'h00, 8'h00, 4'h0};
    tbl[2]  = '{8'h00, 8'h80, 8'h80, 8'h00, 4'hD};
    tbl[3]  = '{8'h00, 8'h7F, 8'h01, 8'h80, 4'h6};
    tbl[4]  = '{8'h01, 8'h03, 8'h05, 8'hFE, 4'hA};
    tbl[5]  = '{8'h01, 8'h80, 8'h01, 8'h7F, 4'h4};
    tbl[6]  = '{8'hFF, 8'h00, 8'h00, 8'h00, 4'h0};
    tbl[7]  = '{8'h02, 8'hF0, 8'h3C, 8'h30, 4'h0};
    tbl[8]  = '{8'h03, 8'h0F, 8'hF0, 8'hFF, 4'h2};
    tbl[9]  = '{8'h04, 8'hAA, 8'hAA, 8'h00, 4'h1};
    tbl[10] = '{8'h05, 8'h81, 8'h00, 8'h02, 4'h8};
    tbl[11] = '{8'h06, 8'h01, 8'h00, 8'h00, 4'h9};
    tbl[12] = '{8'h07, 8'h9C, 8'h00, 8'h9C, 4'h2};
    for (int d = 0; d < 2; d++) begin
      in_valid[d] = 1'b0;
      in_data[d] = 8'h00;
      res_ready[d] = 1'b0;
    end
    repeat (2) tick();
    do_reset();
    for (int i = 0; i < 13; i++)
      frame(0, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].f, i % 3, i == 0);
    for (int i = 0; i < 6; i++)
      frame(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].y, tbl[i].f, 2, i == 0);
    // Result held back for 10 cycles, then one handshake only.
    send(0, 8'h01, 0);
    send(0, 8'h09, 0);
    send(0, 8'h04, 0);
    n = 0;
    while (!res_valid[0] && n < 40) begin
      tick();
      n++;
    end
    ok = 1'b1;
    repeat (10) begin
      if (!res_valid[0] || in_ready[0] || res_data[0] !== 8'h05 || res_flags[0] !== 4'h0 || res_err[0])
        ok = 1'b0;
      tick();
    end
    chk("hold_stable", ok, 1);
    res_ready[0] = 1'b1;
    repeat (3) tick();
    res_ready[0] = 1'b0;
    exp_cnt[0]++;
    exp_b[0] = 8'h04;
    chk("hold_one_hs", frame_cnt[0], exp_cnt[0]);
    chk("hold_valid", res_valid[0], 0);
    // Reset mid-frame after the A byte; the stale A must not leak into the next frame.
    send(0, 8'h00, 0);
    send(0, 8'h11, 0);
    do_reset();
    frame(0, 8'h00, 8'h22, 8'h01, 8'h23, 4'h0, 0, 0);
    for (int i = 0; i < 1000; i++) begin
      op = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      a = 8'($urandom);
      b = 8'($urandom);
      m = (|op[7:3]) ? 12'h000 : alu_model(op[2:0], a, b);
      frame(0, op, a, b, m[7:0], m[11:8], 3, 1'($urandom_range(0, 1)));
    end
    do_reset();
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      m = alu_model(3'(i), a, b);
      frame(0, 8'(i % 8), a, b, m[7:0], m[11:8], 0, 1);
    end
    chk("cnt_wrap", frame_cnt[0], 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
